// File: rtl/alu_main.sv
// 32-bit ALU: combinational add/sub/shift/logic plus a shared 1-bit/cycle multiply/divide engine.
// Optional feature macro ALU_REM_EN: opcode 11 returns the unsigned remainder from the divide engine.
module alu_main #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       control,
  output logic [WIDTH-1:0] s,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_MUL = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SHL = 4'd3;
  localparam logic [3:0] OP_SHR = 4'd4;
  localparam logic [3:0] OP_SAR = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_OR  = 4'd7;
  localparam logic [3:0] OP_NOT = 4'd8;
  localparam logic [3:0] OP_XOR = 4'd9;
  localparam logic [3:0] OP_DIV = 4'd10;
  localparam logic [3:0] OP_REM = 4'd11;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [3:0]         ctrl_q;
  logic [3:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               ovf_q, ovf_d;

  logic               is_mc_s, changed_s, start_s, abort_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_r2_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   div_diff_s;
  logic [WIDTH-1:0]   s_c;
  logic               carry_c, ovf_c;

  always_comb begin
    is_mc_s = (control == OP_MUL) || (control == OP_DIV);
`ifdef ALU_REM_EN
    if (control == OP_REM) begin
      is_mc_s = 1'b1;
    end else begin
      is_mc_s = is_mc_s;
    end
`endif
  end

  assign changed_s = (a != a_q) || (b != b_q) || (control != ctrl_q);
  assign start_s   = changed_s && is_mc_s;
  assign abort_s   = changed_s && !is_mc_s;

  // Multiply keeps {partial_hi, multiplier} in prod_q; divide keeps {remainder, dividend/quotient}.
  assign mul_sum_s  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign div_r2_s   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign div_ge_s   = div_r2_s >= {1'b0, opnd_q};
  assign div_diff_s = div_r2_s[WIDTH-1:0] - opnd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      ctrl_q  <= 4'd0;
      op_q    <= 4'd0;
      cnt_q   <= {CNT_W{1'b0}};
      opnd_q  <= {WIDTH{1'b0}};
      prod_q  <= {(2*WIDTH){1'b0}};
      res_q   <= {WIDTH{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a;
      b_q     <= b;
      ctrl_q  <= control;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      prod_q  <= prod_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    prod_d  = prod_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          case (op_q)
            OP_MUL: begin
              res_d = prod_q[WIDTH-1:0];
              ovf_d = |prod_q[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
              res_d = (opnd_q == {WIDTH{1'b0}}) ? {WIDTH{1'b1}} : prod_q[WIDTH-1:0];
              ovf_d = (opnd_q == {WIDTH{1'b0}});
            end
            default: begin
              // Remainder by zero naturally leaves the dividend in the upper half.
              res_d = prod_q[2*WIDTH-1:WIDTH];
              ovf_d = (opnd_q == {WIDTH{1'b0}});
            end
          endcase
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (op_q == OP_MUL) begin
            prod_d = {mul_sum_s, prod_q[WIDTH-1:1]};
          end else begin
            prod_d = {(div_ge_s ? div_diff_s : div_r2_s[WIDTH-1:0]), prod_q[WIDTH-2:0], div_ge_s};
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (start_s) begin
      state_d = ST_RUN;
      op_d    = control;
      cnt_d   = {CNT_W{1'b0}};
      opnd_d  = (control == OP_MUL) ? a : b;
      prod_d  = {{WIDTH{1'b0}}, ((control == OP_MUL) ? b : a)};
    end else if (abort_s) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  always_comb begin
    s_c     = {WIDTH{1'b0}};
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    case (control)
      OP_ADD: begin
        {carry_c, s_c} = {1'b0, a} + {1'b0, b};
        ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (s_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        {carry_c, s_c} = {1'b0, a} - {1'b0, b};
        ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (s_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHL: begin
        s_c     = {a[WIDTH-2:0], 1'b0};
        carry_c = a[WIDTH-1];
      end
      OP_SHR: begin
        s_c     = {1'b0, a[WIDTH-1:1]};
        carry_c = a[0];
      end
      OP_SAR: begin
        s_c     = {a[WIDTH-1], a[WIDTH-1:1]};
        carry_c = a[0];
      end
      OP_AND: s_c = a & b;
      OP_OR:  s_c = a | b;
      OP_NOT: s_c = ~a;
      OP_XOR: s_c = a ^ b;
      OP_MUL, OP_DIV: begin
        s_c   = res_q;
        ovf_c = ovf_q;
      end
`ifdef ALU_REM_EN
      OP_REM: begin
        s_c   = res_q;
        ovf_c = ovf_q;
      end
`endif
      default: begin
        s_c = {WIDTH{1'b0}};
      end
    endcase
  end

  assign s        = rst_n ? s_c : {WIDTH{1'b0}};
  assign carry    = rst_n ? carry_c : 1'b0;
  assign overflow = rst_n ? ovf_c : 1'b0;
  assign zero     = (s == {WIDTH{1'b0}});
  assign busy     = (state_q == ST_RUN);

endmodule

// File: tb/tb_alu_main.sv
// Scoreboard bench for alu_main: stimulus pushes expected results, a monitor pops and compares.
module tb_alu_main;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [3:0]  control = 4'd0;
  logic [31:0] s;
  logic        carry, overflow, zero, busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] s;
    logic        c;
    logic        o;
    logic        z;
    bit          mc;
    bit          lat;
  } exp_t;

  exp_t sb_q[$];

  alu_main dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .control(control),
    .s(s), .carry(carry), .overflow(overflow), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void check_out(input exp_t e);
    checks++;
    if (s !== e.s || carry !== e.c || overflow !== e.o || zero !== e.z || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got s=%0d c=%b o=%b z=%b busy=%b, want s=%0d c=%b o=%b z=%b busy=0",
               e.name, s, carry, overflow, zero, busy, e.s, e.c, e.o, e.z);
    end
  endfunction

  // Monitor: single-cycle items compare at the next negedge; multi-cycle items after busy falls.
  initial begin
    int   cyc;
    int   bcyc;
    bit   seen;
    exp_t e;
    cyc = 0; bcyc = 0; seen = 1'b0;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q[0];
        if (!e.mc) begin
          check_out(e);
          void'(sb_q.pop_front());
        end else begin
          cyc++;
          if (busy) begin
            seen = 1'b1;
            bcyc++;
          end
          if (seen && !busy) begin
            check_out(e);
            if (e.lat) begin
              checks++;
              if (bcyc != 33) begin
                errors++;
                $display("FAIL %s latency: busy for %0d cycles, want 33", e.name, bcyc);
              end
            end
            void'(sb_q.pop_front());
            cyc = 0; bcyc = 0; seen = 1'b0;
          end else if (cyc > 150) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: busy=%b after %0d cycles, want completion", e.name, busy, cyc);
            void'(sb_q.pop_front());
            cyc = 0; bcyc = 0; seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic drive(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk);
    #1;
    control = c;
    a = x;
    b = y;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
  endtask

  task automatic expect_res(input string nm, input logic [31:0] es, input logic ec,
                            input logic eo, input logic ez, input bit mc, input bit lat);
    exp_t e;
    e.name = nm; e.s = es; e.c = ec; e.o = eo; e.z = ez; e.mc = mc; e.lat = lat;
    sb_q.push_back(e);
    drain();
  endtask

  task automatic op(input string nm, input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                    input logic [31:0] es, input logic ec, input logic eo, input logic ez, input bit mc);
    drive(c, x, y);
    expect_res(nm, es, ec, eo, ez, mc, mc);
  endtask

  initial begin
    control = 4'd0; a = 32'd5; b = 32'd3;
    expect_res("reset", 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    op("add_carry", 4'd0, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    op("add_zero",  4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    op("add_ovf",   4'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    op("sub_eq",    4'd2, 32'd4567, 32'd4567, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    op("sub_borrow",4'd2, 32'd5235255, 32'd5255425, 32'hFFFF_B136, 1'b1, 1'b0, 1'b0, 1'b0);
    op("sub_ovf",   4'd2, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    op("shl",       4'd3, 32'd32, 32'd0, 32'd64, 1'b0, 1'b0, 1'b0, 1'b0);
    op("shl_carry", 4'd3, 32'h8000_0001, 32'd0, 32'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    op("shr",       4'd4, 32'hFFFF_FFFF, 32'd0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    op("sar",       4'd5, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    op("and",       4'd6, 32'd65563, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    op("or",        4'd7, 32'd65562, 32'd1, 32'd65563, 1'b0, 1'b0, 1'b0, 1'b0);
    op("not",       4'd8, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    op("xor",       4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    op("reserved",  4'd12, 32'd5, 32'd3, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    op("mul_small", 4'd1, 32'd36544, 32'd262, 32'd9574528, 1'b0, 1'b0, 1'b0, 1'b1);
    op("mul_ovf",   4'd1, 32'd743896, 32'd3333583, 32'd1642929576, 1'b0, 1'b1, 1'b0, 1'b1);
    op("mul_wrap",  4'd1, 32'd65536, 32'd65536, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    op("div_503",   4'd10, 32'd503, 32'd10, 32'd50, 1'b0, 1'b0, 1'b0, 1'b1);
    op("div_15",    4'd10, 32'd15, 32'd1, 32'd15, 1'b0, 1'b0, 1'b0, 1'b1);
    op("div_zero",  4'd10, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1);
    op("div_big",   4'd10, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    op("div_max",   4'd10, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef ALU_REM_EN
    op("rem",       4'd11, 32'd503, 32'd10, 32'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    op("rem_zero",  4'd11, 32'd7, 32'd0, 32'd7, 1'b0, 1'b1, 1'b0, 1'b1);
`else
    op("rem_off",   4'd11, 32'd503, 32'd10, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // Change divisor mid-run: the result must come from the new operands.
    drive(4'd10, 32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    drive(4'd10, 32'd1000, 32'd10);
    expect_res("div_restart", 32'd100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-run clears outputs; after release the held operands recompute.
    drive(4'd10, 32'd999, 32'd3);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    expect_res("reset_midop", 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    expect_res("div_after_rst", 32'd333, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
